// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI mode-3 initiator: FSM encodings, bus idle levels, word size.
package spi_master_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_TRAIL = 3'd4;

  localparam logic SPI_SS_IDLE   = 1'b1;
  localparam logic SPI_SCLK_IDLE = 1'b1;
  localparam int   SPI_BITS      = 8;

endpackage

// File: rtl/spi_master_clkgen.sv
// DIV-cycle phase timer: phase_end marks the last cycle of a phase, last_next predicts it one cycle early.
module spi_clkgen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic phase_end,
  output logic last_next
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_d;

  // last_next lets the FSM register txready so it lands in a phase's final cycle
  always_comb begin
    phase_end = run && (cnt == LAST);
    if (restart || !run || phase_end) cnt_d = '0;
    else                              cnt_d = cnt + 8'd1;
    last_next = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-3 burst initiator (CPOL=1, CPHA=1, MSB first) with a byte-stream fabric interface.
// Optional internal loopback of mosi into the rx shifter: define SPI_MASTER_LOOPBACK_EN.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DIV = 2,
  parameter int NW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] nbytes,
  input  logic [7:0]    txdata,
  output logic          txready,
  output logic [7:0]    rxdata,
  output logic          rxvalid,
  output logic          busy,
  output logic          ss,
  output logic          sclk,
  output logic          mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic          loopback,
`endif
  input  logic          miso
);

  localparam logic [2:0] TOP_BIT = 3'(SPI_BITS - 1);

  // Handshake: txready is a one-cycle request; txdata is taken at the clk edge ending that cycle.
  // rxvalid is a one-cycle strobe qualifying rxdata; there is no back-pressure on either side.

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic [NW-1:0] bytes_left;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          accept;
  logic          more_bytes;
  logic          in_bit;
  logic          txready_d;
  logic          phase_end;
  logic          last_next;
  logic          restart;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  assign in_bit = lb_q ? mosi : miso;
`else
  assign in_bit = miso;
`endif

  assign accept     = (state == ST_IDLE) && start && (nbytes != '0);
  assign more_bytes = (bytes_left > NW'(1));
  assign restart    = (state_nxt != state);

  spi_clkgen #(.DIV(DIV)) u_clkgen (
    .clk       (clk),
    .reset     (reset),
    .run       (state != ST_IDLE),
    .restart   (restart),
    .phase_end (phase_end),
    .last_next (last_next)
  );

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_idx;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SETUP;
          bit_nxt   = TOP_BIT;
        end
      end
      ST_SETUP: if (phase_end) state_nxt = ST_LOW;
      ST_LOW:   if (phase_end) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (phase_end) begin
          // 3-bit index wraps 0 -> 7, starting the next byte with no gap
          bit_nxt = bit_idx - 3'd1;
          if (bit_idx == 3'd0 && !more_bytes) state_nxt = ST_TRAIL;
          else                                state_nxt = ST_LOW;
        end
      end
      ST_TRAIL: if (phase_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    txready_d = last_next &&
                ((state_nxt == ST_SETUP) ||
                 ((state_nxt == ST_HIGH) && (bit_nxt == 3'd0) && more_bytes));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      bytes_left <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      ss         <= SPI_SS_IDLE;
      sclk       <= SPI_SCLK_IDLE;
      mosi       <= 1'b1;
      busy       <= 1'b0;
      txready    <= 1'b0;
      rxvalid    <= 1'b0;
      rxdata     <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_nxt;
      txready <= txready_d;
      rxvalid <= 1'b0;

      if (accept) begin
        bytes_left <= nbytes;
        busy       <= 1'b1;
        ss         <= ~SPI_SS_IDLE;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_q       <= loopback;
`endif
      end

      if (state_nxt == ST_LOW && state != ST_LOW) begin
        sclk <= ~SPI_SCLK_IDLE;
        if (bit_nxt == TOP_BIT) begin
          tx_sh <= txdata;
          mosi  <= txdata[7];
        end else begin
          mosi  <= tx_sh[6];
          tx_sh <= {tx_sh[6:0], 1'b0};
        end
      end

      if (state == ST_LOW && state_nxt == ST_HIGH) begin
        sclk  <= SPI_SCLK_IDLE;
        rx_sh <= {rx_sh[6:0], in_bit};
        if (bit_idx == 3'd0) begin
          rxvalid <= 1'b1;
          rxdata  <= {rx_sh[6:0], in_bit};
        end
      end

      if (state == ST_HIGH && phase_end && bit_idx == 3'd0)
        bytes_left <= bytes_left - NW'(1);

      if (state_nxt == ST_TRAIL && state != ST_TRAIL) begin
        ss   <= SPI_SS_IDLE;
        sclk <= SPI_SCLK_IDLE;
        mosi <= 1'b1;
      end

      if (state == ST_TRAIL && phase_end)
        busy <= 1'b0;
    end
  end

endmodule
